// File: rtl/axi_stream_video_gen.sv
// AXI4-Stream video frame source: emits width x height frames of a selectable test
// pattern, tuser on the first pixel of a frame and tlast on the last pixel of each line.
module axi_stream_video_gen #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int H_BLANK            = 0
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic                            continuous,
    input  logic                            stop,
    input  logic [15:0]                     cfg_width,
    input  logic [15:0]                     cfg_height,
    input  logic [1:0]                      cfg_pattern,
    input  logic [31:0]                     cfg_color,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            cfg_error,
    output logic [1:0]                      state_dbg
);

    // Handshake: a beat moves on a rising clk edge where tvalid && tready; tvalid comes
    // from state only, and the payload is a function of registered x/y/config, so it
    // holds still for as long as tvalid && !tready.

    typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_FRAME_END} state_t;

    localparam logic [15:0] BLANK_LAST = 16'(H_BLANK > 0 ? H_BLANK - 1 : 0);

    state_t      state, state_next;
    logic [15:0] x_q, y_q, width_q, height_q, blank_cnt;
    logic [1:0]  pattern_q;
    logic [31:0] color_q;
    logic [31:0] pix;
    logic        stop_pend;
    logic        xfer, last_x, last_y, cfg_ok;
    logic        do_latch, err_next;

    assign xfer      = (state == S_LINE) && m_axis_tready;
    assign last_x    = (x_q == width_q - 16'd1);
    assign last_y    = (y_q == height_q - 16'd1);
    assign cfg_ok    = (cfg_width != 16'd0) && (cfg_height != 16'd0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_latch   = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        do_latch   = 1'b1;
                        state_next = S_LINE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_LINE: begin
                if (xfer && last_x) begin
                    if (last_y)           state_next = S_FRAME_END;
                    else if (H_BLANK > 0) state_next = S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (blank_cnt == BLANK_LAST) state_next = S_LINE;
            end
            S_FRAME_END: begin
                state_next = S_IDLE;
                // A stop arriving in this very cycle also ends the run.
                if (continuous && !stop_pend && !stop) begin
                    if (cfg_ok) begin
                        do_latch   = 1'b1;
                        state_next = S_LINE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            y_q       <= '0;
            width_q   <= '0;
            height_q  <= '0;
            pattern_q <= '0;
            color_q   <= '0;
            blank_cnt <= '0;
            stop_pend <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= err_next;
            if (do_latch) begin
                width_q   <= cfg_width;
                height_q  <= cfg_height;
                pattern_q <= cfg_pattern;
                color_q   <= cfg_color;
                x_q       <= '0;
                y_q       <= '0;
            end else if (xfer) begin
                if (last_x) begin
                    x_q <= '0;
                    if (!last_y) y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end
            blank_cnt <= (state == S_HBLANK) ? blank_cnt + 16'd1 : 16'd0;
            if (state_next == S_IDLE)         stop_pend <= 1'b0;
            else if (stop && state != S_IDLE) stop_pend <= 1'b1;
        end
    end

    always_comb begin
        pix = '0;
        unique case (pattern_q)
            2'd0: pix = {y_q, x_q};
            2'd1: pix = color_q;
            2'd2: pix = {16'd0, x_q};
            2'd3: pix = (x_q[3] ^ y_q[3]) ? 32'hFFFF_FFFF : 32'd0;
            default: pix = '0;
        endcase
    end

    always_comb begin
        m_axis_tvalid     = (state == S_LINE);
        m_axis_tdata      = '0;
        if (m_axis_tvalid) m_axis_tdata[31:0] = pix;
        m_axis_tlast      = m_axis_tvalid && last_x;
        m_axis_tuser      = m_axis_tvalid && (x_q == 16'd0) && (y_q == 16'd0);
        busy              = (state != S_IDLE);
        frame_done        = (state == S_FRAME_END);
    end

    assign m_axis_tstrb = '1;

endmodule

// File: tb/tb_axi_stream_video_gen.sv
// Directed bench for axi_stream_video_gen: expected beats are queued when a frame is
// started and checked as the stream monitor sees them accepted.
module tb_axi_stream_video_gen;

    localparam int W  = 32;
    localparam int EW = 34;  // {tuser, tlast, tdata}

    logic          clk, resetn, start, continuous, stop;
    logic [15:0]   cfg_width, cfg_height;
    logic [1:0]    cfg_pattern;
    logic [31:0]   cfg_color;
    logic          tvalid, tready, tlast, tuser, busy, frame_done, cfg_error;
    logic [W-1:0]  tdata;
    logic [W/8-1:0] tstrb;
    logic [1:0]    state_dbg;

    logic          b_tvalid, b_tlast, b_tuser, b_busy, b_frame_done, b_cfg_error;
    logic [W-1:0]  b_tdata;
    logic [W/8-1:0] b_tstrb;
    logic [1:0]    b_state_dbg;

    logic [EW-1:0] exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic          rand_ready = 1'b0;

    // monitor bookkeeping
    int            sof_cnt = 0, fd_cnt = 0;
    int            cur_beats = 0, cur_lines = 0, meas_w = 0, meas_h = 0;
    logic          seen_sof = 1'b0, prev_stall = 1'b0;
    logic [EW-1:0] held;

    axi_stream_video_gen #(.C_AXIS_TDATA_WIDTH(W), .H_BLANK(0)) dut (
        .clk(clk), .resetn(resetn), .start(start), .continuous(continuous), .stop(stop),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pattern(cfg_pattern),
        .cfg_color(cfg_color), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tdata(tdata), .m_axis_tstrb(tstrb), .m_axis_tlast(tlast),
        .m_axis_tuser(tuser), .busy(busy), .frame_done(frame_done),
        .cfg_error(cfg_error), .state_dbg(state_dbg)
    );

    axi_stream_video_gen #(.C_AXIS_TDATA_WIDTH(W), .H_BLANK(3)) dut_blank (
        .clk(clk), .resetn(resetn), .start(start), .continuous(continuous), .stop(stop),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pattern(cfg_pattern),
        .cfg_color(cfg_color), .m_axis_tvalid(b_tvalid), .m_axis_tready(1'b1),
        .m_axis_tdata(b_tdata), .m_axis_tstrb(b_tstrb), .m_axis_tlast(b_tlast),
        .m_axis_tuser(b_tuser), .busy(b_busy), .frame_done(b_frame_done),
        .cfg_error(b_cfg_error), .state_dbg(b_state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] pix(input int x, input int y, input logic [1:0] pat,
                                        input logic [31:0] col);
        logic [15:0] xs, ys;
        xs = 16'(x);
        ys = 16'(y);
        case (pat)
            2'd0:    return {ys, xs};
            2'd1:    return col;
            2'd2:    return {16'd0, xs};
            default: return (xs[3] ^ ys[3]) ? 32'hFFFF_FFFF : 32'd0;
        endcase
    endfunction

    task automatic push_frame(input int w, input int h, input logic [1:0] pat,
                              input logic [31:0] col);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back({(x == 0 && y == 0), (x == w - 1), pix(x, y, pat, col)});
    endtask

    // driver tasks: inputs change 1 time unit after the active edge
    task automatic set_cfg(input int w, input int h, input logic [1:0] pat,
                           input logic [31:0] col);
        cfg_width   = 16'(w);
        cfg_height  = 16'(h);
        cfg_pattern = pat;
        cfg_color   = col;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || b_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy | b_busy, 0);
    endtask

    task automatic wait_sof(input int target, input int max_cycles);
        int n;
        n = 0;
        while (sof_cnt < target && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("sof_timeout", sof_cnt >= target, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard / stream monitor, sampled mid-cycle
    initial begin
        logic [EW-1:0] payload, exp;
        forever begin
            @(negedge clk);
            payload = {tuser, tlast, tdata};
            if (!resetn) begin
                prev_stall = 1'b0;
                seen_sof   = 1'b0;
                cur_beats  = 0;
                cur_lines  = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", tvalid, 1);
                    check("hold_payload", payload, held);
                end
                if (frame_done) fd_cnt++;
                if (tvalid && tready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        check("beat", payload, exp);
                    end
                    if (tuser) begin
                        if (seen_sof) meas_h = cur_lines;
                        seen_sof  = 1'b1;
                        cur_lines = 0;
                        cur_beats = 0;
                        sof_cnt++;
                    end
                    cur_beats++;
                    if (tlast) begin
                        meas_w    = cur_beats;
                        cur_beats = 0;
                        cur_lines++;
                    end
                end
                prev_stall = tvalid && !tready;
                held       = payload;
            end
        end
    end

    initial begin
        logic [8:0] v_vec, fd_vec;
        int base, nvalid;
        resetn = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 2'd0, 32'd0);

        // reset values
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tstrb", tstrb, 4'hF);
        check("rst_tlast", tlast, 0);
        check("rst_tuser", tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_error", cfg_error, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // 4x3 coordinate pattern, full throughput
        set_cfg(4, 3, 2'd0, 32'd0);
        push_frame(4, 3, 2'd0, 32'd0);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t1_valid", tvalid, 1);
            if (i == 5) check("t1_beat5", tdata, 32'h0001_0001);
        end
        @(negedge clk);
        check("t1_frame_done", frame_done, 1);
        check("t1_valid_end", tvalid, 0);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_frame_done_pulse", frame_done, 0);
        wait_idle(100);

        // same frame under back-pressure; config and start change mid-frame
        rand_ready = 1'b1;
        push_frame(4, 3, 2'd0, 32'd0);
        pulse_start();
        set_cfg(7, 9, 2'd1, 32'hDEAD_BEEF);
        pulse_start();
        wait_idle(500);
        check("t2_queue_empty", exp_q.size(), 0);

        // checker pattern under back-pressure
        set_cfg(20, 10, 2'd3, 32'd0);
        push_frame(20, 10, 2'd3, 32'd0);
        pulse_start();
        wait_idle(2000);
        check("t3_queue_empty", exp_q.size(), 0);

        // horizontal blanking on the H_BLANK=3 instance
        rand_ready = 1'b0;
        set_cfg(2, 2, 2'd1, 32'hA5A5_1234);
        push_frame(2, 2, 2'd1, 32'hA5A5_1234);
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            v_vec[8-i]  = b_tvalid;
            fd_vec[8-i] = b_frame_done;
        end
        check("hblank_valid_seq", v_vec, 9'b110001100);
        check("hblank_frame_done_seq", fd_vec, 9'b000000010);
        wait_idle(100);

        // continuous 3x2, stop during frame 2
        rand_ready = 1'b1;
        continuous = 1'b1;
        set_cfg(3, 2, 2'd2, 32'd0);
        push_frame(3, 2, 2'd2, 32'd0);
        push_frame(3, 2, 2'd2, 32'd0);
        base = fd_cnt;
        pulse_start();
        wait_sof(sof_cnt + 2, 200);
        pulse_stop();
        wait_idle(200);
        check("cont_queue_empty", exp_q.size(), 0);
        check("cont_frames", fd_cnt - base, 2);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tvalid) nvalid++;
        end
        check("cont_no_valid_after_stop", nvalid, 0);
        continuous = 1'b0;

        // zero width request
        set_cfg(0, 4, 2'd0, 32'd0);
        pulse_start();
        @(negedge clk);
        check("zero_cfg_error", cfg_error, 1);
        check("zero_tvalid", tvalid, 0);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_cfg_error_pulse", cfg_error, 0);

        // reset mid-line
        rand_ready = 1'b0;
        set_cfg(4, 3, 2'd0, 32'd0);
        push_frame(4, 3, 2'd0, 32'd0);
        pulse_start();
        repeat (6) @(negedge clk);
        check("rst_mid_valid_before", tvalid, 1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_valid_drop", tvalid, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_resume", tvalid, 0);
        push_frame(4, 3, 2'd0, 32'd0);
        pulse_start();
        @(negedge clk);
        check("rst_restart_tuser", tuser, 1);
        check("rst_restart_tdata", tdata, 0);
        wait_idle(100);

        // size measurement of a continuous 8x5 stream
        continuous = 1'b1;
        set_cfg(8, 5, 2'd0, 32'd0);
        push_frame(8, 5, 2'd0, 32'd0);
        push_frame(8, 5, 2'd0, 32'd0);
        pulse_start();
        wait_sof(sof_cnt + 2, 300);
        check("loop_width", meas_w, 8);
        check("loop_height", meas_h, 5);
        pulse_stop();
        wait_idle(300);
        continuous = 1'b0;
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
